// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the processor front end.
//
// Holds the current instruction address and selects the next one:
// sequential step, absolute jump, signed relative branch, call or return.
// Calls and returns go through a circular return-address stack (RAS).
// A one-cycle registered redirect pulse follows every taken
// non-sequential transfer so fetch/decode can flush.
//
// Ports:
//   clock         in   system clock, rising edge
//   clear         in   synchronous active-high reset (highest priority)
//   stall         in   hold all state; op ignored
//   op[2:0]       in   0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 as SEQ
//   target        in   absolute destination for JUMP / CALL
//   offset        in   two's-complement displacement for BRANCH
//   ppc           out  current PC (registered)
//   redirect      out  high one cycle after an accepted JUMP/BRANCH/CALL/RET
//   ras_count     out  number of valid RAS entries (saturates at RAS_DEPTH)
//   ras_overflow  out  sticky: a CALL overwrote the oldest entry
//   ras_underflow out  sticky: a RET found the RAS empty
module pc_unit #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VEC = '0,
    parameter logic [WIDTH-1:0]       STEP      = WIDTH'(1),
    parameter int unsigned            OFF_W     = 8,
    parameter int unsigned            RAS_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             stall,
    input  logic [2:0]                       op,
    input  logic [WIDTH-1:0]                 target,
    input  logic [OFF_W-1:0]                 offset,
    output logic [WIDTH-1:0]                 ppc,
    output logic                             redirect,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redir_q, redir_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             push;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] off_ext;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    op_e              op_dec;

    assign op_dec  = op_e'(op);
    assign seq_pc  = pc_q + STEP;
    assign off_ext = WIDTH'($signed(offset));

    // ptr_q is the next free slot; top of stack sits one below it.
    // When full, the next free slot is also the oldest entry, so a push
    // naturally overwrites it and the newest RAS_DEPTH entries stay LIFO.
    assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        redir_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!stall) begin
            case (op_dec)
                OP_JUMP: begin
                    pc_d    = target;
                    redir_d = 1'b1;
                end
                OP_BRANCH: begin
                    pc_d    = pc_q + off_ext;
                    redir_d = 1'b1;
                end
                OP_CALL: begin
                    push    = 1'b1;
                    pc_d    = target;
                    redir_d = 1'b1;
                    ptr_d   = ptr_inc;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (cnt_q != '0) begin
                        pc_d    = ras_q[ptr_dec];
                        redir_d = 1'b1;
                        ptr_d   = ptr_dec;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end
                end
                default: begin
                    pc_d = seq_pc;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q    <= RESET_VEC;
            redir_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry contents need no reset; clear only suppresses the push.
    always_ff @(posedge clock) begin
        if (!clear && push) begin
            ras_q[ptr_q] <= seq_pc;
        end
    end

    assign ppc           = pc_q;
    assign redirect      = redir_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed-vector bench for pc_unit
// (WIDTH=8, STEP=1, RESET_VEC=0x10, OFF_W=8, RAS_DEPTH=4).
module tb_pc_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned OFF_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] SEQ = 3'd0, JUMP = 3'd1, BRANCH = 3'd2,
                           CALL = 3'd3, RET = 3'd4, RSV5 = 3'd5;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             stall = 1'b0;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] target = '0;
    logic [OFF_W-1:0] offset = '0;
    logic [WIDTH-1:0] ppc;
    logic             redirect;
    logic [CW-1:0]    ras_count;
    logic             ras_overflow;
    logic             ras_underflow;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_VEC(8'h10),
        .STEP     (8'h01),
        .OFF_W    (OFF_W),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .stall        (stall),
        .op           (op),
        .target       (target),
        .offset       (offset),
        .ppc          (ppc),
        .redirect     (redirect),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [2:0] o, input logic [7:0] t,
                        input logic [7:0] off, input logic s, input logic c);
        op     = o;
        target = t;
        offset = off;
        stall  = s;
        clear  = c;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pc(input string tag, input logic [7:0] pc,
                             input logic red, input logic [31:0] cnt);
        check({tag, ".ppc"}, 32'(ppc), 32'(pc));
        check({tag, ".redirect"}, 32'(redirect), 32'(red));
        check({tag, ".ras_count"}, 32'(ras_count), cnt);
    endtask

    task automatic expect_flags(input string tag, input logic ovf, input logic unf);
        check({tag, ".ovf"}, 32'(ras_overflow), 32'(ovf));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(unf));
    endtask

    initial begin
        #2;
        // reset and sequential flow
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b1);
        expect_pc("reset", 8'h10, 1'b0, 0);
        expect_flags("reset", 1'b0, 1'b0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("seq1", 8'h11, 1'b0, 0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("seq2", 8'h12, 1'b0, 0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("seq3", 8'h13, 1'b0, 0);

        // wrap and branch
        step(JUMP, 8'hFE, 8'h00, 1'b0, 1'b0);
        expect_pc("jmpFE", 8'hFE, 1'b1, 0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("seqFF", 8'hFF, 1'b0, 0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("wrap00", 8'h00, 1'b0, 0);
        step(BRANCH, 8'h00, 8'hFC, 1'b0, 1'b0);
        expect_pc("br_neg", 8'hFC, 1'b1, 0);
        step(BRANCH, 8'h00, 8'h05, 1'b0, 1'b0);
        expect_pc("br_pos", 8'h01, 1'b1, 0);
        step(SEQ, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("br_done", 8'h02, 1'b0, 0);

        // stall
        step(JUMP, 8'h20, 8'h00, 1'b0, 1'b0);
        expect_pc("jmp20", 8'h20, 1'b1, 0);
        step(JUMP, 8'h80, 8'h00, 1'b1, 1'b0);
        expect_pc("stall1", 8'h20, 1'b0, 0);
        step(JUMP, 8'h80, 8'h00, 1'b1, 1'b0);
        expect_pc("stall2", 8'h20, 1'b0, 0);
        step(JUMP, 8'h80, 8'h00, 1'b0, 1'b0);
        expect_pc("release", 8'h80, 1'b1, 0);

        // nested calls
        step(JUMP, 8'h00, 8'h00, 1'b0, 1'b0);
        step(CALL, 8'h40, 8'h00, 1'b0, 1'b0);
        expect_pc("call40", 8'h40, 1'b1, 1);
        step(CALL, 8'h60, 8'h00, 1'b0, 1'b0);
        expect_pc("call60", 8'h60, 1'b1, 2);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ret41", 8'h41, 1'b1, 1);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ret01", 8'h01, 1'b1, 0);
        expect_flags("nested", 1'b0, 1'b0);

        // overflow: five calls into a four-entry stack
        step(JUMP, 8'h00, 8'h00, 1'b0, 1'b0);
        step(CALL, 8'hA0, 8'h00, 1'b0, 1'b0);
        step(CALL, 8'hB0, 8'h00, 1'b0, 1'b0);
        step(CALL, 8'hC0, 8'h00, 1'b0, 1'b0);
        step(CALL, 8'hD0, 8'h00, 1'b0, 1'b0);
        expect_pc("full", 8'hD0, 1'b1, 4);
        expect_flags("full", 1'b0, 1'b0);
        step(CALL, 8'hE0, 8'h00, 1'b0, 1'b0);
        expect_pc("ovf_call", 8'hE0, 1'b1, 4);
        expect_flags("ovf_call", 1'b1, 1'b0);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ovf_retD1", 8'hD1, 1'b1, 3);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ovf_retC1", 8'hC1, 1'b1, 2);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ovf_retB1", 8'hB1, 1'b1, 1);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ovf_retA1", 8'hA1, 1'b1, 0);

        // underflow, reserved op, sticky flags
        step(JUMP, 8'h33, 8'h00, 1'b0, 1'b0);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("unf", 8'h34, 1'b0, 0);
        expect_flags("unf", 1'b1, 1'b1);
        step(RSV5, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_pc("rsv5", 8'h35, 1'b0, 0);
        expect_flags("rsv5", 1'b1, 1'b1);

        // clear wins over a simultaneous CALL
        step(CALL, 8'h99, 8'h00, 1'b0, 1'b1);
        expect_pc("clr_call", 8'h10, 1'b0, 0);
        expect_flags("clr_call", 1'b0, 1'b0);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("clr_nopush", 8'h11, 1'b0, 0);
        expect_flags("clr_nopush", 1'b0, 1'b1);

        // call then immediate return, with a stalled RET between
        step(CALL, 8'h50, 8'h00, 1'b0, 1'b0);
        expect_pc("call50", 8'h50, 1'b1, 1);
        step(RET, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_pc("stall_ret", 8'h50, 1'b0, 1);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_pc("ret12", 8'h12, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the processor front end. Holds the current instruction address and computes the next one: sequential step, absolute jump, signed relative branch, call or return. Calls and returns use an internal circular return-address stack (RAS). Emits a registered redirect pulse that the fetch and decode stages use to flush on non-sequential flow.

Parameters:
WIDTH, 8, address width in bits; all PC arithmetic is modulo 2^WIDTH.
RESET_VEC, 0, PC value loaded by clear.
STEP, 1, increment applied for sequential flow and for return-address computation.
OFF_W, 8, width of the signed branch offset; legal range is OFF_W <= WIDTH.
RAS_DEPTH, 4, number of return-address stack entries; legal range is RAS_DEPTH >= 2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
stall  input  1  when high, hold all state; op is ignored.
op  input  3  flow operation: 0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 reserved.
target  input  WIDTH  absolute destination for JUMP and CALL.
offset  input  OFF_W  two's-complement displacement for BRANCH.
ppc  output  WIDTH  current PC (registered).
redirect  output  1  registered; high for one cycle after an accepted JUMP, BRANCH, CALL or RET.
ras_count  output  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
ras_overflow  output  1  sticky; set when a CALL overwrites the oldest entry.
ras_underflow  output  1  sticky; set when a RET occurs with an empty RAS.

Behaviour:
- One clock; reset is synchronous and active-high. The reset port is clear and the clock port is clock.
- clear is sampled only on the rising clock edge and has priority over everything else.
- On clear:
  - ppc = RESET_VEC, redirect = 0, ras_count = 0, ras_overflow = 0, ras_underflow = 0.
  - RAS pointer returns to 0. Entry contents are don't-care.
  - No initial blocks are used; clear is the only initialisation.
- Priority order: clear > stall > op.
- stall = 1:
  - ppc, RAS, ras_count and both flags hold.
  - redirect = 0 on the next cycle.
- Accepted op (not stalled, not cleared). Every update is visible on ppc one cycle after the edge.
  - SEQ: ppc <= ppc + STEP. redirect <= 0.
  - JUMP: ppc <= target. redirect <= 1.
  - BRANCH: ppc <= ppc + sign_extend(offset, WIDTH). redirect <= 1.
  - CALL: push (ppc + STEP) onto RAS. ppc <= target. redirect <= 1.
  - RET, RAS non-empty: pop the top entry. ppc <= popped value. redirect <= 1.
  - RET, RAS empty: ppc <= ppc + STEP. redirect <= 0. ras_underflow <= 1. ras_count stays 0.
  - Reserved ops 5-7: behave exactly as SEQ. No flag is set.
- Arithmetic: all sums truncate to WIDTH bits. Wrap-around is legal and silent.
  - Example: WIDTH = 8, ppc = 0xFF, SEQ gives 0x00.
- RAS organisation: circular buffer of RAS_DEPTH entries, top-of-stack pointer, and ras_count saturating at RAS_DEPTH.
- CALL with ras_count == RAS_DEPTH:
  - The new entry overwrites the oldest entry (circular wrap).
  - ras_count stays RAS_DEPTH.
  - ras_overflow <= 1.
  - The RAS_DEPTH most recent return addresses remain poppable in LIFO order.
- Stack update timing:
  - The pushed value is ppc + STEP, using ppc before the update.
  - A CALL followed immediately by a RET returns to the CALL's ppc + STEP; there is no bypass hazard.
- redirect is cleared on the first non-redirecting cycle. Back-to-back redirecting ops hold redirect high continuously.
- Sticky flags: once set, they stay set until clear.
- Reset mid-operation: clear asserted on the same edge as a CALL or RET wins completely. No push or pop occurs, and the flags are cleared.

Test Plan:
- Reset and sequential flow (WIDTH=8, STEP=1, RESET_VEC=0x10): hold clear for 1 cycle, then 3 cycles of SEQ -> ppc reads 0x10, 0x11, 0x12, 0x13; redirect stays 0 throughout.
- Wrap and branch: from ppc=0xFE, SEQ, SEQ -> 0xFF, 0x00. Then BRANCH offset=0xFC (-4) -> 0xFC with redirect=1 for one cycle; then BRANCH offset=0x05 -> 0x01.
- Stall: at ppc=0x20, stall=1 with op=JUMP target=0x80 for 2 cycles -> ppc stays 0x20 and redirect=0. Release with op=JUMP -> ppc=0x80 and redirect=1.
- Nested calls: at ppc=0x00, CALL 0x40; at 0x40, CALL 0x60; then RET, RET -> ppc 0x40, 0x60, 0x41, 0x01; ras_count goes 1, 2, 1, 0.
- Overflow (RAS_DEPTH=4): 5 consecutive CALLs from ppc values 0x00, 0xA0, 0xB0, 0xC0, 0xD0 -> ras_overflow=1 and ras_count=4. Four RETs yield 0xD1, 0xC1, 0xB1, 0xA1; the 0x01 entry is lost.
- Underflow and clear: RET with an empty RAS at ppc=0x33 -> ppc=0x34, ras_underflow=1, redirect=0. Then assert clear on the same edge as a CALL -> ppc=RESET_VEC, ras_count=0, both flags 0.
